// File: rtl/dm_cmd_splitter.sv
// dm_cmd_splitter: splits one large transfer request into CHUNK_BYTES-aligned
// AXI DataMover 72-bit commands, bounds the number of in-flight commands and
// folds the returned status stream into one done/error result per request.
//
// Ports:
//   axi_aclk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only while idle)
//   req_addr/req_len/req_eof      start address, byte count (0 allowed), EOF flag
//   cmd_tdata/cmd_tvalid/ready    DataMover command stream
//   sts_tdata/sts_tvalid/ready    DataMover status stream (always accepted)
//   done_valid/done_err           one-cycle completion pulse and error flag
//   busy                          request accepted and not yet completed
//   outstanding                   commands issued minus statuses received
module dm_cmd_splitter #(
  parameter int unsigned CHUNK_BYTES     = 1024,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        axi_aclk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_len,
  input  logic        req_eof,
  output logic [71:0] cmd_tdata,
  output logic        cmd_tvalid,
  input  logic        cmd_tready,
  input  logic [7:0]  sts_tdata,
  input  logic        sts_tvalid,
  output logic        sts_tready,
  output logic        done_valid,
  output logic        done_err,
  output logic        busy,
  output logic [3:0]  outstanding
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BTT_W  = 23;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CMD_W  = 72;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_STS,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]  rem_q, rem_d;
  logic               eof_q, eof_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   exp_tag_q, exp_tag_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic               cmd_tvalid_q, cmd_tvalid_d;
  logic [CMD_W-1:0]   cmd_tdata_q, cmd_tdata_d;
  logic               done_valid_q, done_valid_d;
  logic               done_err_q, done_err_d;
  logic               busy_q, busy_d;
  logic               req_ready_q, req_ready_d;

  logic [ADDR_W-1:0]  offset_c, room_c, chunk_c, issued_c;
  logic               cmd_hs_c, sts_dec_c, sts_bad_c;

  // Next chunk: limited by distance to the next CHUNK_BYTES boundary and by what is left.
  always_comb begin
    offset_c = cur_addr_q & 32'(CHUNK_BYTES - 1);
    room_c   = 32'(CHUNK_BYTES) - offset_c;
    chunk_c  = (rem_q < room_c) ? rem_q : room_c;
    issued_c = 32'(cmd_tdata_q[BTT_W-1:0]);
  end

  // Status beats with nothing outstanding are unexpected: they flag an error but do not count.
  always_comb begin
    cmd_hs_c  = cmd_tvalid_q && cmd_tready;
    sts_dec_c = sts_tvalid && (outst_q != '0);
    sts_bad_c = sts_tvalid && ((outst_q == '0) || !sts_tdata[7] || (|sts_tdata[6:4]) ||
                               (sts_tdata[3:0] != exp_tag_q));
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    eof_d        = eof_q;
    tag_d        = tag_q;
    exp_tag_d    = exp_tag_q;
    err_d        = err_q;
    outst_d      = outst_q + {3'b000, cmd_hs_c} - {3'b000, sts_dec_c};
    cmd_tvalid_d = cmd_tvalid_q;
    cmd_tdata_d  = cmd_tdata_q;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;
    busy_d       = busy_q;

    if (sts_dec_c) exp_tag_d = exp_tag_q + 4'd1;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cur_addr_d = req_addr;
          rem_d      = req_len;
          eof_d      = req_eof;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = (req_len != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (cmd_hs_c) begin
          cur_addr_d   = cur_addr_q + issued_c;
          rem_d        = rem_q - issued_c;
          tag_d        = tag_q + 4'd1;
          cmd_tvalid_d = 1'b0;
          if (rem_q == issued_c) state_d = S_WAIT_STS;
        end else if (!cmd_tvalid_q && (rem_q != '0) &&
                     (outst_q < 4'(MAX_OUTSTANDING))) begin
          cmd_tvalid_d = 1'b1;
          cmd_tdata_d  = {4'b0000, tag_q, cur_addr_q, 1'b0, eof_q && (chunk_c == rem_q),
                          6'b000000, 1'b1, chunk_c[BTT_W-1:0]};
        end
      end
      S_WAIT_STS: begin
        if (outst_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done_valid_d = 1'b1;
        done_err_d   = err_q;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A bad status in the accept cycle still counts against the new request.
    if (sts_bad_c) err_d = 1'b1;

    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      rem_q        <= '0;
      eof_q        <= 1'b0;
      tag_q        <= '0;
      exp_tag_q    <= '0;
      err_q        <= 1'b0;
      outst_q      <= '0;
      cmd_tvalid_q <= 1'b0;
      cmd_tdata_q  <= '0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      rem_q        <= rem_d;
      eof_q        <= eof_d;
      tag_q        <= tag_d;
      exp_tag_q    <= exp_tag_d;
      err_q        <= err_d;
      outst_q      <= outst_d;
      cmd_tvalid_q <= cmd_tvalid_d;
      cmd_tdata_q  <= cmd_tdata_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign cmd_tdata   = cmd_tdata_q;
  assign cmd_tvalid  = cmd_tvalid_q;
  assign sts_tready  = 1'b1;
  assign done_valid  = done_valid_q;
  assign done_err    = done_err_q;
  assign busy        = busy_q;
  assign outstanding = outst_q;

endmodule

// File: tb/tb_dm_cmd_splitter.sv
// Testbench for dm_cmd_splitter: random and directed requests checked against
// a behavioural split model, a status-return queue and an outstanding counter.
module tb_dm_cmd_splitter;

  localparam int unsigned CHUNK = 1024;
  localparam int unsigned MAXO  = 4;

  logic        axi_aclk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_len;
  logic        req_eof;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid;
  logic        sts_tready;
  logic        done_valid;
  logic        done_err;
  logic        busy;
  logic [3:0]  outstanding;

  int tests  = 0;
  int failed = 0;

  logic [71:0] exp_q[$];
  logic [3:0]  ret_q[$];
  logic [3:0]  tb_tag = 4'd0;

  dm_cmd_splitter #(.CHUNK_BYTES(CHUNK), .MAX_OUTSTANDING(MAXO)) dut (
    .axi_aclk(axi_aclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_eof(req_eof),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
    .done_valid(done_valid), .done_err(done_err), .busy(busy),
    .outstanding(outstanding)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  // Expected command list for a request, straight from the chunking rules.
  function automatic void build(input logic [31:0] a, input logic [31:0] l, input logic e);
    longint unsigned rem = 64'(l);
    logic [31:0] cur = a;
    longint unsigned room, c;
    while (rem > 0) begin
      room = 64'(CHUNK) - 64'(cur % CHUNK);
      c    = (rem < room) ? rem : room;
      exp_q.push_back({4'b0, tb_tag, cur, 1'b0, e && (c == rem), 6'b0, 1'b1, 23'(c)});
      cur  = cur + 32'(c);
      rem  = rem - c;
      tb_tag = tb_tag + 4'd1;
    end
  endfunction

  // rdy_mode: 0 always ready, 1 random, 2 stall for cycles 2..6.
  // hold: no statuses returned before this cycle. err_kind: 1 SLVERR on 2nd status, 2 bad tag on 1st.
  task automatic do_request(input logic [31:0] a, input logic [31:0] l, input logic e,
                            input int rdy_mode, input int hold, input int err_kind);
    int exp_out = 0;
    int n_sts = 0;
    int cyc = 0;
    bit done_seen = 0;
    bit hs_p = 0, sts_p = 0, stall_p = 0;
    logic [71:0] data_p = '0;
    logic [71:0] exp;
    logic [3:0] t;
    logic [7:0] s;
    logic exp_err = (err_kind != 0);
    exp_q.delete();
    ret_q.delete();
    build(a, l, e);
    req_addr = a; req_len = l; req_eof = e; req_valid = 1'b1;
    tests++;
    if (req_ready !== 1'b1) begin
      failed++; $display("FAIL req_ready_idle got %b exp 1", req_ready);
    end
    @(posedge axi_aclk); #1;
    req_valid = 1'b0;
    while (!done_seen && cyc < 2000) begin
      if (hs_p) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++; $display("FAIL cmd_extra got %h exp none", data_p);
        end else begin
          exp = exp_q.pop_front();
          if (data_p !== exp) begin
            failed++; $display("FAIL cmd_data got %h exp %h", data_p, exp);
          end
          ret_q.push_back(exp[67:64]);
        end
        exp_out++;
      end
      if (sts_p) exp_out--;
      if (stall_p) begin
        tests++;
        if (cmd_tvalid !== 1'b1 || cmd_tdata !== data_p) begin
          failed++; $display("FAIL cmd_hold got %b/%h exp 1/%h", cmd_tvalid, cmd_tdata, data_p);
        end
      end
      tests++;
      if (outstanding !== 4'(exp_out) || exp_out > int'(MAXO)) begin
        failed++; $display("FAIL outstanding got %0d exp %0d", outstanding, exp_out);
      end
      if (cyc == 0) begin
        tests++;
        if (cmd_tvalid !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b1) begin
          failed++; $display("FAIL accept_cycle got v%b d%b b%b exp v0 d0 b1", cmd_tvalid, done_valid, busy);
        end
      end
      if (cyc == 1) begin
        tests++;
        if (l != 0 && cmd_tvalid !== 1'b1) begin
          failed++; $display("FAIL first_cmd_latency got %b exp 1", cmd_tvalid);
        end else if (l == 0 && (done_valid !== 1'b1 || cmd_tvalid !== 1'b0)) begin
          failed++; $display("FAIL zero_len_done got d%b v%b exp d1 v0", done_valid, cmd_tvalid);
        end
      end
      if (hold > 0 && cyc == hold) begin
        tests++;
        if (outstanding !== 4'(MAXO) || cmd_tvalid !== 1'b0) begin
          failed++; $display("FAIL outstanding_limit got %0d/v%b exp %0d/v0", outstanding, cmd_tvalid, MAXO);
        end
      end
      if (done_valid === 1'b1) begin
        done_seen = 1;
        tests++;
        if (done_err !== exp_err) begin
          failed++; $display("FAIL done_err got %b exp %b", done_err, exp_err);
        end
        tests++;
        if (exp_q.size() != 0 || ret_q.size() != 0 || exp_out != 0 || busy !== 1'b0) begin
          failed++; $display("FAIL done_early got cmds_left %0d sts_left %0d out %0d busy %b exp 0 0 0 0",
                             exp_q.size(), ret_q.size(), exp_out, busy);
        end
      end else begin
        tests++;
        if (busy !== 1'b1) begin
          failed++; $display("FAIL busy got %b exp 1", busy);
        end
        cmd_tready = (rdy_mode == 0) ? 1'b1 :
                     (rdy_mode == 1) ? 1'($urandom_range(0, 1)) :
                     ((cyc >= 2 && cyc < 7) ? 1'b0 : 1'b1);
        if (ret_q.size() > 0 && cyc >= hold && $urandom_range(0, 1) == 1) begin
          t = ret_q.pop_front();
          n_sts++;
          s = {1'b1, 3'b000, t};
          if (err_kind == 1 && n_sts == 2) s[6] = 1'b1;
          if (err_kind == 2 && n_sts == 1) s[3:0] = t + 4'd5;
          sts_tdata = s; sts_tvalid = 1'b1; sts_p = 1;
        end else begin
          sts_tvalid = 1'b0; sts_p = 0;
        end
        hs_p    = cmd_tvalid && cmd_tready;
        stall_p = cmd_tvalid && !cmd_tready;
        data_p  = cmd_tdata;
        @(posedge axi_aclk); #1;
        cyc++;
      end
    end
    sts_tvalid = 1'b0;
    cmd_tready = 1'b0;
    if (!done_seen) begin
      tests++; failed++; $display("FAIL done_timeout got none exp done_valid");
    end
    @(posedge axi_aclk); #1;
    tests++;
    if (done_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failed++; $display("FAIL after_done got d%b b%b r%b exp d0 b0 r1", done_valid, busy, req_ready);
    end
  endtask

  task automatic test_reset();
    tests++;
    if (cmd_tvalid !== 1'b0 || cmd_tdata !== 72'h0 || done_valid !== 1'b0 || done_err !== 1'b0 ||
        busy !== 1'b0 || outstanding !== 4'd0 || req_ready !== 1'b1 || sts_tready !== 1'b1) begin
      failed++;
      $display("FAIL reset_state got v%b d%h dv%b de%b b%b o%0d r%b s%b exp all idle",
               cmd_tvalid, cmd_tdata, done_valid, done_err, busy, outstanding, req_ready, sts_tready);
    end
  endtask

  task automatic test_basic_split();
    do_request(32'h0000_1000, 32'd3000, 1'b1, 0, 0, 0);
    do_request(32'h0000_0F00, 32'd600, 1'b0, 1, 0, 0);
  endtask

  task automatic test_backpressure();
    do_request(32'h0000_0000, 32'd8192, 1'b1, 0, 20, 0);
    do_request(32'h0000_2000, 32'd4096, 1'b0, 2, 0, 0);
  endtask

  task automatic test_errors();
    do_request(32'h0000_1000, 32'd3000, 1'b1, 1, 0, 1);
    do_request(32'h0000_1000, 32'd3000, 1'b1, 1, 0, 2);
  endtask

  task automatic test_zero_len_and_stray();
    do_request(32'h0000_1234, 32'd0, 1'b1, 0, 0, 0);
    sts_tdata = 8'h80; sts_tvalid = 1'b1;
    @(posedge axi_aclk); #1;
    sts_tvalid = 1'b0;
    tests++;
    if (outstanding !== 4'd0) begin
      failed++; $display("FAIL stray_no_underflow got %0d exp 0", outstanding);
    end
    do_request(32'h0000_4000, 32'd2048, 1'b1, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    req_addr = 32'h0000_8000; req_len = 32'd8192; req_eof = 1'b1; req_valid = 1'b1;
    cmd_tready = 1'b1;
    @(posedge axi_aclk); #1;
    req_valid = 1'b0;
    while (!(outstanding == 4'd2 && cmd_tvalid == 1'b1) && cyc < 100) begin
      @(posedge axi_aclk); #1;
      cyc++;
    end
    if (cyc >= 100) begin
      tests++; failed++; $display("FAIL reset_mid_wait got out %0d exp 2", outstanding);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (cmd_tvalid !== 1'b0 || busy !== 1'b0 || outstanding !== 4'd0) begin
      failed++; $display("FAIL reset_mid got v%b b%b o%0d exp v0 b0 o0", cmd_tvalid, busy, outstanding);
    end
    cmd_tready = 1'b0;
    @(posedge axi_aclk); #1;
    rst = 1'b0;
    tb_tag = 4'd0;
    @(posedge axi_aclk); #1;
    do_request(32'h0000_2000, 32'd2048, 1'b1, 1, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, l;
    for (int i = 0; i < 10; i++) begin
      a = (i == 0) ? 32'hFFFF_FE00 : 32'($urandom);
      l = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 6000));
      do_request(a, l, 1'($urandom_range(0, 1)), 1, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_len = '0; req_eof = 1'b0;
    cmd_tready = 1'b0; sts_tdata = '0; sts_tvalid = 1'b0;
    repeat (3) @(posedge axi_aclk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge axi_aclk); #1;
    test_reset();
    test_basic_split();
    test_backpressure();
    test_errors();
    test_zero_len_and_stray();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
